// File: rtl/pattern_stream_ctrl.sv
// Word-to-bit-serial sequencer wrapped around an overlapping pattern matcher.
// Each accepted word is shifted MSB-first through a persistent history; matches are counted per word.
module pattern_stream_ctrl #(
  parameter int WORD_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 4,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [CNT_W-1:0]   out_count,
  input  logic               out_ready,
  output logic               match_pulse,
  output logic               busy
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(PAT_MAX);
  localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};
  localparam logic [PAT_MAX-1:0] PAT_RST = PAT_MAX'(4'b1011);
  localparam logic [LEN_W-1:0]   LEN_RST = LEN_W'(4);

  logic [1:0]         state_q;
  logic [WORD_W-1:0]  word_q;
  logic [IDX_W-1:0]   idx_q;
  logic [PAT_MAX-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic [PAT_MAX-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               pulse_q;

  logic               shift_bit;
  logic [PAT_MAX-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic [PAT_MAX-1:0] len_msk;
  logic               match;

  function automatic logic [LEN_W-1:0] sat_fill(input logic [LEN_W-1:0] f);
    return (f >= LEN_MAX) ? LEN_MAX : f + LEN_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && (c != CNT_MAX)) ? c + CNT_W'(1) : c;
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > LEN_MAX) ? LEN_MAX : l;
  endfunction

  function automatic logic [PAT_MAX-1:0] len_mask(input logic [LEN_W-1:0] l);
    logic [PAT_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < PAT_MAX; i++) m[i] = (i < int'(l));
    return m;
  endfunction

  // Match is judged on the history and fill as they will be after this bit lands.
  always_comb begin
    shift_bit = word_q[idx_q];
    hist_n    = PAT_MAX'({hist_q, shift_bit});
    fill_n    = sat_fill(fill_q);
    len_msk   = len_mask(len_q);
    match     = (state_q == S_SHIFT) && (len_q != '0) && (fill_n >= len_q) &&
                (((hist_n ^ pat_q) & len_msk) == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= PAT_RST;
      len_q   <= LEN_RST;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= match;
      case (state_q)
        S_IDLE: begin
          // A configuration write takes priority over a word offered in the same cycle.
          if (cfg_we) begin
            pat_q  <= cfg_pat;
            len_q  <= clamp_len(cfg_len);
            hist_q <= '0;
            fill_q <= '0;
          end else if (in_valid) begin
            word_q  <= in_data;
            idx_q   <= IDX_W'(WORD_W - 1);
            cnt_q   <= '0;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          hist_q <= hist_n;
          fill_q <= fill_n;
          cnt_q  <= sat_cnt(cnt_q, match);
          idx_q  <= idx_q - IDX_W'(1);
          if (idx_q == '0) state_q <= S_REPORT;
        end
        S_REPORT: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == S_IDLE) && !cfg_we;
  assign out_valid   = (state_q == S_REPORT);
  assign out_count   = cnt_q;
  assign busy        = (state_q != S_IDLE);
  assign match_pulse = pulse_q;

endmodule

// File: tb/tb_pattern_stream_ctrl.sv
// Directed bench for pattern_stream_ctrl: hand-computed counts and pulse positions per word.
module tb_pattern_stream_ctrl;

  localparam int WORD_W  = 8;
  localparam int PAT_MAX = 8;
  localparam int CNT_W   = 4;
  localparam int LEN_W   = 4;

  logic               clk;
  logic               reset_n;
  logic               cfg_we;
  logic [PAT_MAX-1:0] cfg_pat;
  logic [LEN_W-1:0]   cfg_len;
  logic               in_valid;
  logic [WORD_W-1:0]  in_data;
  logic               in_ready;
  logic               out_valid;
  logic [CNT_W-1:0]   out_count;
  logic               out_ready;
  logic               match_pulse;
  logic               busy;

  int n_chk  = 0;
  int n_pass = 0;

  pattern_stream_ctrl #(
    .WORD_W(WORD_W), .PAT_MAX(PAT_MAX), .CNT_W(CNT_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_count(out_count), .out_ready(out_ready),
    .match_pulse(match_pulse), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_word(input logic [WORD_W-1:0] w);
    in_data  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = ~w;
  endtask

  // Shifts the accepted word, recording match_pulse after each bit edge; optional cfg_we pulse mid-word.
  task automatic shift_check(input string tag, input int exp_cnt, input logic [WORD_W-1:0] exp_pm,
                             input int cfg_at);
    logic [WORD_W-1:0] pm;
    pm = '0;
    for (int i = 0; i < WORD_W; i++) begin
      if (i == cfg_at) begin
        cfg_we  = 1'b1;
        cfg_pat = 8'h00;
        cfg_len = 4'd0;
      end
      tick();
      cfg_we = 1'b0;
      pm[i] = match_pulse;
      if (i == WORD_W - 2) check({tag, "_vld_early"}, out_valid, 0);
    end
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_cnt"}, out_count, exp_cnt);
    check({tag, "_pulses"}, pm, exp_pm);
  endtask

  task automatic finish_report(input string tag);
    out_ready = 1'b1;
    tick();
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic cfg_write(input logic [PAT_MAX-1:0] p, input logic [LEN_W-1:0] l);
    cfg_we  = 1'b1;
    cfg_pat = p;
    cfg_len = l;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    logic [CNT_W-1:0] held;
    logic             bad;
    reset_n   = 1'b0;
    cfg_we    = 1'b0;
    cfg_pat   = '0;
    cfg_len   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_count", out_count, 0);
    check("rst_busy", busy, 0);
    check("rst_pulse", match_pulse, 0);
    check("rst_in_ready", in_ready, 1);
    #2 reset_n = 1'b1;
    tick();

    // Default pattern 1011 / length 4
    accept_word(8'b1011_1011);
    check("t1_busy", busy, 1);
    shift_check("t1", 2, 8'b1000_1000, -1);
    finish_report("t1");

    accept_word(8'b1011_0110);
    shift_check("t2", 2, 8'b0100_1000, -1);
    finish_report("t2");

    accept_word(8'b0000_0101);
    shift_check("t3a", 0, 8'b0000_0000, -1);
    finish_report("t3a");
    accept_word(8'b1000_0000);
    shift_check("t3b", 1, 8'b0000_0001, -1);
    finish_report("t3b");

    // Backpressure in REPORT with a word waiting
    out_ready = 1'b0;
    accept_word(8'b1011_1011);
    shift_check("t4", 2, 8'b1000_1000, -1);
    in_data  = 8'h00;
    in_valid = 1'b1;
    held = out_count;
    bad  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!out_valid || out_count !== held || in_ready) bad = 1'b1;
    end
    check("t4_hold", bad, 0);
    check("t4_hold_cnt", out_count, 2);
    out_ready = 1'b1;
    tick();
    check("t4_hs_idle", busy, 0);
    check("t4_hs_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_data  = 8'hFF;
    check("t4_accepted", busy, 1);
    shift_check("t4b", 0, 8'b0000_0000, -1);
    finish_report("t4b");

    // cfg_we wins over in_valid, then mid-shift cfg_we is ignored
    cfg_we   = 1'b1;
    cfg_pat  = 8'b0000_0111;
    cfg_len  = 4'd3;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    #1;
    check("t5_cfg_ready", in_ready, 0);
    tick();
    cfg_we = 1'b0;
    check("t5_not_taken", busy, 0);
    tick();
    in_valid = 1'b0;
    check("t5_taken", busy, 1);
    shift_check("t5", 6, 8'b1111_1100, 3);
    finish_report("t5");

    cfg_write(8'h00, 4'd0);
    accept_word(8'hFF);
    shift_check("len0", 0, 8'b0000_0000, -1);
    finish_report("len0");

    cfg_write(8'hFF, 4'd15);
    accept_word(8'hFF);
    shift_check("clamp", 1, 8'b1000_0000, -1);
    finish_report("clamp");

    // Async reset mid-word
    accept_word(8'hFF);
    tick();
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_vld", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_cnt", out_count, 0);
    check("t6_rst_pulse", match_pulse, 0);
    tick();
    reset_n = 1'b1;
    check("t6_in_ready", in_ready, 1);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid || busy) bad = 1'b1;
    end
    check("t6_no_report", bad, 0);
    accept_word(8'b0000_1011);
    shift_check("t6", 1, 8'b1000_0000, -1);
    finish_report("t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
